wb_arbiter_n: RTL

WB_ARBITER_N -- requirements
Module: wb_arbiter_n

---
 rtl/wb_arbiter_n_pkg.sv | 21 ++
 rtl/wb_arb_pick.sv | 36 +++
 rtl/wb_arbiter_n.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_n_pkg.sv
// Shared interconnect definitions for the N-master Wishbone arbiter:
// FSM state encoding, arbitration-mode constants and the watchdog width helper.
package wb_arbiter_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_ERRWAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    PRIO_RR    = 1'b0,
    PRIO_FIXED = 1'b1
  } prio_mode_e;

  // A disabled or tiny watchdog still needs a 1-bit counter to stay a legal vector.
  function automatic int wd_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational rotating-base priority encoder: one-hot winner among req,
// searching upward from base (round-robin) or from index 0 (fixed priority).
module wb_arb_pick
  import wb_arbiter_n_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  input  prio_mode_e    mode,
  output logic [N-1:0]  gnt
);

  int   start_s;
  int   idx_s;
  logic found_s;

  // first requester found while walking the ring from the start index wins
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    idx_s   = 0;
    start_s = (mode == PRIO_FIXED) ? 0 : int'(base);
    for (int i = 0; i < N; i++) begin
      idx_s = (start_s + i) % N;
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master Wishbone arbiter with round-robin or fixed priority, whole-cycle
// ownership (bursts never split) and a stall watchdog that raises a bus error.
module wb_arbiter_n
  import wb_arbiter_n_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int AW        = 24,
  parameter int DW        = 16,
  parameter int SW        = 2,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_MASTERS-1:0]    m_cyc,
  input  logic [N_MASTERS-1:0]    m_stb,
  input  logic [N_MASTERS-1:0]    m_we,
  input  logic [N_MASTERS*AW-1:0] m_adr,
  input  logic [N_MASTERS*DW-1:0] m_o_dat,
  input  logic [N_MASTERS*SW-1:0] m_sel,
  input  logic [N_MASTERS-1:0]    m_4_burst,
  input  logic [N_MASTERS-1:0]    m_8_burst,
  output logic [N_MASTERS-1:0]    m_ack,
  output logic [N_MASTERS-1:0]    m_err,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [AW-1:0]           s_adr,
  output logic [DW-1:0]           s_o_dat,
  output logic [SW-1:0]           s_sel,
  output logic                    s_4_burst,
  output logic                    s_8_burst,
  input  logic                    s_ack,
  input  logic                    s_err,
  output logic [N_MASTERS-1:0]    o_grant,
  output logic                    o_busy
);

  localparam int             IW     = $clog2(N_MASTERS);
  localparam int             WDW    = wd_width(TIMEOUT);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
  localparam prio_mode_e     MODE   = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;

  logic [AW-1:0] adr_a [N_MASTERS];
  logic [DW-1:0] dat_a [N_MASTERS];
  logic [SW-1:0] sel_a [N_MASTERS];

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_slice
    assign adr_a[k] = m_adr[k*AW +: AW];
    assign dat_a[k] = m_o_dat[k*DW +: DW];
    assign sel_a[k] = m_sel[k*SW +: SW];
  end

  arb_state_e           state_r, state_nx_s;
  logic [N_MASTERS-1:0] grant_r, grant_nx_s, winner_s;
  logic [IW-1:0]        gidx_r, gidx_nx_s, winner_idx_s, last_r, last_nx_s, base_s;
  logic [WDW-1:0]       wd_r, wd_nx_s;
  logic                 cyc_g_s, stb_g_s, tmo_s;

  assign base_s = (last_r == IW'(N_MASTERS - 1)) ? '0 : last_r + 1'b1;

  wb_arb_pick #(.N(N_MASTERS), .IW(IW)) u_pick (
    .req  (m_cyc),
    .base (base_s),
    .mode (MODE),
    .gnt  (winner_s)
  );

  // one-hot winner to index, so the granted master's slices can be muxed directly
  always_comb begin
    winner_idx_s = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (winner_s[i]) begin
        winner_idx_s = IW'(i);
      end else begin
        winner_idx_s = winner_idx_s;
      end
    end
  end

  // next-state, watchdog and bus routing; the timeout cycle kills s_cyc/s_stb
  always_comb begin
    state_nx_s = state_r;
    grant_nx_s = grant_r;
    gidx_nx_s  = gidx_r;
    last_nx_s  = last_r;
    wd_nx_s    = wd_r;
    m_ack      = '0;
    m_err      = '0;
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_adr      = '0;
    s_o_dat    = '0;
    s_sel      = '0;
    s_4_burst  = 1'b0;
    s_8_burst  = 1'b0;
    tmo_s      = 1'b0;
    cyc_g_s    = m_cyc[gidx_r];
    stb_g_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        wd_nx_s = '0;
        if (|m_cyc) begin
          state_nx_s = ST_ACTIVE;
          grant_nx_s = winner_s;
          gidx_nx_s  = winner_idx_s;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        tmo_s     = (TIMEOUT != 0) && cyc_g_s && (wd_r == WD_MAX) && !s_ack && !s_err;
        stb_g_s   = m_stb[gidx_r] & ~tmo_s;
        s_cyc     = cyc_g_s & ~tmo_s;
        s_stb     = stb_g_s;
        s_we      = m_we[gidx_r];
        s_adr     = adr_a[gidx_r];
        s_o_dat   = dat_a[gidx_r];
        s_sel     = sel_a[gidx_r];
        s_4_burst = m_4_burst[gidx_r];
        s_8_burst = m_8_burst[gidx_r];
        m_ack[gidx_r] = s_ack;
        m_err[gidx_r] = s_err | tmo_s;
        if (s_ack || s_err) begin
          wd_nx_s = '0;
        end else if (stb_g_s && (wd_r != WD_MAX)) begin
          wd_nx_s = wd_r + 1'b1;
        end else begin
          wd_nx_s = wd_r;
        end
        if (!cyc_g_s) begin
          state_nx_s = ST_IDLE;
          grant_nx_s = '0;
          last_nx_s  = gidx_r;
        end else if (tmo_s) begin
          state_nx_s = ST_ERRWAIT;
        end else begin
          state_nx_s = ST_ACTIVE;
        end
      end
      ST_ERRWAIT: begin
        if (!cyc_g_s) begin
          state_nx_s = ST_IDLE;
          grant_nx_s = '0;
          last_nx_s  = gidx_r;
        end else begin
          state_nx_s = ST_ERRWAIT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        grant_nx_s = '0;
      end
    endcase
  end

  // state register; last_r resets to the top index so master 0 wins first
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      gidx_r  <= '0;
      last_r  <= IW'(N_MASTERS - 1);
      wd_r    <= '0;
    end else begin
      state_r <= state_nx_s;
      grant_r <= grant_nx_s;
      gidx_r  <= gidx_nx_s;
      last_r  <= last_nx_s;
      wd_r    <= wd_nx_s;
    end
  end

  assign o_grant = grant_r;
  assign o_busy  = (state_r != ST_IDLE);

endmodule
